// File: rtl/div_issue_ctrl.sv
// EXE-stage issue/fix-up controller for the iterative unsigned divider (RV32M DIV/DIVU/REM/REMU).
// Optional macro DIV_FAST_PATH_EN: zero dividend or zero divisor complete locally without the divider.
module div_issue_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            valid_in,
    input  logic [1:0]      op_in,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic            flush_in,
    output logic            busy_out,
    output logic            done_out,
    output logic [XLEN-1:0] result_out,
    output logic            div_req_out,
    output logic            div_is_q_out,
    output logic [XLEN-1:0] div_dividend_out,
    output logic [XLEN-1:0] div_divitor_out,
    input  logic            div_ready_in,
    input  logic [XLEN-1:0] div_result_in
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [XLEN-1:0] ONE = XLEN'(1);

    logic [1:0]      r_state;
    logic            r_signed;
    logic            r_neg_a;
    logic            r_neg_b;
    logic            r_b_zero;
    logic [XLEN-1:0] r_raw;

    logic            w_signed;
    logic            w_neg_a;
    logic            w_neg_b;
    logic            w_b_zero;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_accept;
    logic            w_neg_res;
    logic [XLEN-1:0] w_result;

    // funct3[0]==0 selects the signed variants (DIV, REM)
    assign w_signed = ~op_in[0];
    assign w_neg_a  = w_signed & rs1_in[XLEN-1];
    assign w_neg_b  = w_signed & rs2_in[XLEN-1];
    assign w_b_zero = (rs2_in == '0);
    assign w_mag_a  = w_neg_a ? (~rs1_in + ONE) : rs1_in;
    assign w_mag_b  = w_neg_b ? (~rs2_in + ONE) : rs2_in;

    // The done cycle already sits in S_IDLE, so it is excluded from accepting explicitly
    assign w_accept = (r_state == S_IDLE) & valid_in & ~flush_in & ~done_out;

    assign w_neg_res = div_is_q_out ? (r_signed & (r_neg_a ^ r_neg_b) & ~r_b_zero)
                                    : (r_signed & r_neg_a);
    assign w_result  = w_neg_res ? (~r_raw + ONE) : r_raw;

`ifdef DIV_FAST_PATH_EN
    logic w_a_zero;
    assign w_a_zero = (rs1_in == '0);
`endif

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state          <= S_IDLE;
            r_signed         <= 1'b0;
            r_neg_a          <= 1'b0;
            r_neg_b          <= 1'b0;
            r_b_zero         <= 1'b0;
            r_raw            <= '0;
            busy_out         <= 1'b0;
            done_out         <= 1'b0;
            result_out       <= '0;
            div_req_out      <= 1'b0;
            div_is_q_out     <= 1'b0;
            div_dividend_out <= '0;
            div_divitor_out  <= '0;
        end else begin
            done_out <= 1'b0;
            if (flush_in) begin
                r_state     <= S_IDLE;
                div_req_out <= 1'b0;
                busy_out    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_signed         <= w_signed;
                            r_neg_a          <= w_neg_a;
                            r_neg_b          <= w_neg_b;
                            r_b_zero         <= w_b_zero;
                            div_is_q_out     <= ~op_in[1];
                            div_dividend_out <= w_mag_a;
                            div_divitor_out  <= w_mag_b;
                            busy_out         <= 1'b1;
`ifdef DIV_FAST_PATH_EN
                            // Raw unsigned result as the divider would return it
                            if (w_b_zero | w_a_zero) begin
                                r_raw   <= w_b_zero ? (op_in[1] ? w_mag_a : '1) : '0;
                                r_state <= S_FIX;
                            end else begin
                                div_req_out <= 1'b1;
                                r_state     <= S_WAIT;
                            end
`else
                            div_req_out <= 1'b1;
                            r_state     <= S_WAIT;
`endif
                        end
                    end
                    S_WAIT: begin
                        if (div_ready_in) begin
                            r_raw       <= div_result_in;
                            div_req_out <= 1'b0;
                            r_state     <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        result_out <= w_result;
                        done_out   <= 1'b1;
                        busy_out   <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a behavioural fixed-latency unsigned divider.
// Honours DIV_FAST_PATH_EN when deciding whether a request is expected.
module tb_div_issue_ctrl;

    localparam int unsigned XLEN = 32;
    localparam int unsigned DIV_LAT = 8;

    logic            clk_in = 1'b0;
    logic            reset_in;
    logic            valid_in;
    logic [1:0]      op_in;
    logic [XLEN-1:0] rs1_in;
    logic [XLEN-1:0] rs2_in;
    logic            flush_in;
    logic            busy_out;
    logic            done_out;
    logic [XLEN-1:0] result_out;
    logic            div_req_out;
    logic            div_is_q_out;
    logic [XLEN-1:0] div_dividend_out;
    logic [XLEN-1:0] div_divitor_out;
    logic            div_ready_in;
    logic [XLEN-1:0] div_result_in;

    div_issue_ctrl #(.XLEN(XLEN)) dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .valid_in         (valid_in),
        .op_in            (op_in),
        .rs1_in           (rs1_in),
        .rs2_in           (rs2_in),
        .flush_in         (flush_in),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .result_out       (result_out),
        .div_req_out      (div_req_out),
        .div_is_q_out     (div_is_q_out),
        .div_dividend_out (div_dividend_out),
        .div_divitor_out  (div_divitor_out),
        .div_ready_in     (div_ready_in),
        .div_result_in    (div_result_in)
    );

    always #5 clk_in = ~clk_in;

    int unsigned     n_chk = 0;
    int unsigned     n_err = 0;
    logic [XLEN-1:0] q_exp[$];
    logic            prev_rdy = 1'b0;

    typedef struct {
        string           name;
        logic [1:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        logic [XLEN-1:0] dvd;
        logic [XLEN-1:0] dvs;
    } vec_t;

    vec_t vecs[14] = '{
        '{"DIV 20/3",        2'b00, 32'd20,        32'd3,         32'd6,         32'd20,        32'd3},
        '{"REM 20/3",        2'b10, 32'd20,        32'd3,         32'd2,         32'd20,        32'd3},
        '{"DIV -20/3",       2'b00, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 32'd20,        32'd3},
        '{"REM -20/3",       2'b10, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 32'd20,        32'd3},
        '{"DIV 20/-3",       2'b00, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 32'd20,        32'd3},
        '{"REM 20/-3",       2'b10, 32'd20,        32'hFFFF_FFFD, 32'd2,         32'd20,        32'd3},
        '{"DIVU max/2",      2'b01, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd2},
        '{"DIV ovf",         2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd1},
        '{"REM ovf",         2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 32'd1},
        '{"DIV 7/0",         2'b00, 32'd7,         32'd0,         32'hFFFF_FFFF, 32'd7,         32'd0},
        '{"DIV -7/0",        2'b00, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 32'd7,         32'd0},
        '{"REM -7/0",        2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'd7,         32'd0},
        '{"DIVU 0/5",        2'b01, 32'd0,         32'd5,         32'd0,         32'd0,         32'd5},
        '{"REMU 100/7",      2'b11, 32'd100,       32'd7,         32'd2,         32'd100,       32'd7}
    };

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural divider: pulses ready DIV_LAT cycles into a held request
    initial begin
        int unsigned cnt;
        cnt = 0;
        div_ready_in  = 1'b0;
        div_result_in = '0;
        forever begin
            @(posedge clk_in);
            #1;
            div_ready_in = 1'b0;
            if (!div_req_out || reset_in) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == DIV_LAT) begin
                    if (div_divitor_out == '0)
                        div_result_in = div_is_q_out ? '1 : div_dividend_out;
                    else
                        div_result_in = div_is_q_out ? (div_dividend_out / div_divitor_out)
                                                     : (div_dividend_out % div_divitor_out);
                    div_ready_in = 1'b1;
                end
            end
        end
    end

    // Monitor: scoreboard pop on done_out, request-drop check after a sampled ready
    always @(negedge clk_in) begin
        if (reset_in) begin
            prev_rdy = 1'b0;
        end else begin
            if (prev_rdy) begin
                n_chk++;
                if (div_req_out !== 1'b0) begin
                    n_err++;
                    $display("FAIL req_drop: div_req_out=%b after ready sampled, expected 0", div_req_out);
                end
            end
            prev_rdy = div_ready_in;
            if (done_out) begin
                n_chk++;
                if (q_exp.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: result_out=0x%08h with no operation outstanding", result_out);
                end else begin
                    logic [XLEN-1:0] e;
                    e = q_exp.pop_front();
                    if (result_out !== e) begin
                        n_err++;
                        $display("FAIL result: got 0x%08h expected 0x%08h", result_out, e);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int unsigned k;
        k = 0;
        while ((busy_out || done_out) && k < 100) begin
            @(posedge clk_in);
            #1;
            k++;
        end
        if (k >= 100) check("idle_timeout", {31'd0, busy_out}, '0);
    endtask

    task automatic issue(input vec_t v, input bit push);
        logic exp_req;
        wait_idle();
        valid_in = 1'b1;
        op_in    = v.op;
        rs1_in   = v.a;
        rs2_in   = v.b;
        if (push) q_exp.push_back(v.exp);
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
`ifdef DIV_FAST_PATH_EN
        exp_req = !((v.a == '0) || (v.b == '0));
`else
        exp_req = 1'b1;
`endif
        check({v.name, " req"},  {31'd0, div_req_out}, {31'd0, exp_req});
        check({v.name, " busy"}, {31'd0, busy_out}, 32'd1);
        check({v.name, " is_q"}, {31'd0, div_is_q_out}, {31'd0, ~v.op[1]});
        check({v.name, " dvd"},  div_dividend_out, v.dvd);
        check({v.name, " dvs"},  div_divitor_out, v.dvs);
    endtask

    task automatic drain(input string name);
        int unsigned k;
        k = 0;
        while (q_exp.size() != 0 && k < 100) begin
            @(posedge clk_in);
            #1;
            k++;
        end
        check({name, " drain"}, q_exp.size(), 0);
    endtask

    initial begin
        vec_t v;
        reset_in = 1'b1;
        valid_in = 1'b0;
        op_in    = '0;
        rs1_in   = '0;
        rs2_in   = '0;
        flush_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst busy",   {31'd0, busy_out}, '0);
        check("rst done",   {31'd0, done_out}, '0);
        check("rst req",    {31'd0, div_req_out}, '0);
        check("rst is_q",   {31'd0, div_is_q_out}, '0);
        check("rst result", result_out, '0);
        check("rst dvd",    div_dividend_out, '0);
        check("rst dvs",    div_divitor_out, '0);
        reset_in = 1'b0;
        @(posedge clk_in);
        #1;

        foreach (vecs[i]) begin
            issue(vecs[i], 1'b1);
            drain(vecs[i].name);
        end

        // Flush 5 cycles into DIV 100/7: request drops next cycle and no result appears
        v = '{"DIV 100/7 flushed", 2'b00, 32'd100, 32'd7, 32'd14, 32'd100, 32'd7};
        issue(v, 1'b0);
        repeat (4) begin
            @(posedge clk_in);
            #1;
        end
        flush_in = 1'b1;
        @(posedge clk_in);
        #1;
        flush_in = 1'b0;
        check("flush req",  {31'd0, div_req_out}, '0);
        check("flush busy", {31'd0, busy_out}, '0);
        repeat (20) begin
            @(posedge clk_in);
            #1;
        end
        v = '{"DIVU 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 32'd100, 32'd7};
        issue(v, 1'b1);
        drain(v.name);

        // Reset pulse mid-operation clears every output and produces no done
        v = '{"DIV 20/3 reset", 2'b00, 32'd20, 32'd3, 32'd6, 32'd20, 32'd3};
        issue(v, 1'b0);
        repeat (3) begin
            @(posedge clk_in);
            #1;
        end
        #2;
        reset_in = 1'b1;
        #1;
        check("midrst busy",   {31'd0, busy_out}, '0);
        check("midrst done",   {31'd0, done_out}, '0);
        check("midrst req",    {31'd0, div_req_out}, '0);
        check("midrst is_q",   {31'd0, div_is_q_out}, '0);
        check("midrst result", result_out, '0);
        check("midrst dvd",    div_dividend_out, '0);
        check("midrst dvs",    div_divitor_out, '0);
        @(posedge clk_in);
        #3;
        reset_in = 1'b0;
        repeat (20) begin
            @(posedge clk_in);
            #1;
        end
        check("midrst no busy", {31'd0, busy_out}, '0);

        check("final queue", q_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
